div_unit: RTL and testbench

Iterative 32-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU operations. It sits beside the combinational ALU in the execute stage. The ALU produces results combinationally from A/B/ALUop. This block takes operands through a start/busy/done handshake and returns a registered Result that the writeback mux selects in place of the ALU output. Flag outputs follow the ALU's naming so the writeback logic treats both sources the same way.

---
 rtl/div_unit_pkg.sv | 37 +++
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings, FSM states, constants.
package div_unit_pkg;

  localparam int unsigned ITER     = 32;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  localparam logic [1:0] DIV_S = 2'b00;
  localparam logic [1:0] DIV_U = 2'b01;
  localparam logic [1:0] REM_S = 2'b10;
  localparam logic [1:0] REM_U = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_S) || (op == REM_S);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == REM_S) || (op == REM_U);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // |INT_MIN| wraps back to 0x80000000, which is correct read as an unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor, keep or restore.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  localparam int unsigned TW = XLEN + 2;

  logic [TW-1:0] trial;

  // Extra top bit keeps the borrow visible even though rem never exceeds the divisor.
  assign trial = {rem, quo[XLEN-1]} - TW'(divisor);

  always_comb begin
    rem_next = {rem[XLEN-1:0], quo[XLEN-1]};
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (!trial[TW-1]) begin
      rem_next    = trial[XLEN:0];
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with start/busy/done handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [1:0]      DIVop,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result,
  output logic            zero,
  output logic            negative,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int unsigned CNT_W = $clog2(ITER);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op;
  logic             q_neg;
  logic             r_neg;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  divisor;

  logic [XLEN:0]    rem_next;
  logic [XLEN-1:0]  quo_next;

  logic             in_signed;
  logic             in_rem;
  logic             b_zero;
  logic             sgn_ovf;
  logic [XLEN-1:0]  early_res;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;
  logic [XLEN-1:0]  fix_res;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Decode of the incoming request; only used on the accept edge.
  assign in_signed = op_is_signed(DIVop);
  assign in_rem    = op_is_rem(DIVop);
  assign b_zero    = (B == '0);
  assign sgn_ovf   = in_signed && (A == INT_MIN) && (B == ALL_ONES);

  // Divide-by-zero is checked first; it excludes overflow since B cannot be both 0 and -1.
  assign early_res = b_zero ? (in_rem ? A : ALL_ONES)
                            : (in_rem ? '0 : INT_MIN);

  // Sign restoration applied on the FIX edge from the captured op.
  assign q_fix   = q_neg ? neg32(quo) : quo;
  assign r_fix   = r_neg ? neg32(rem[XLEN-1:0]) : rem[XLEN-1:0];
  assign fix_res = op_is_rem(op) ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op          <= DIV_S;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Result      <= '0;
      zero        <= 1'b0;
      negative    <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            op   <= DIVop;
            busy <= 1'b1;
            if (b_zero || sgn_ovf) begin
              Result      <= early_res;
              zero        <= (early_res == '0);
              negative    <= early_res[XLEN-1];
              div_by_zero <= b_zero;
              overflow    <= sgn_ovf && !b_zero;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              rem     <= '0;
              quo     <= in_signed ? abs32(A) : A;
              divisor <= in_signed ? abs32(B) : B;
              q_neg   <= in_signed && (A[XLEN-1] ^ B[XLEN-1]);
              r_neg   <= in_signed && A[XLEN-1];
              cnt     <= '0;
              state   <= CALC;
            end
          end
        end

        CALC: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ITER - 1)) begin
              state <= FIX;
            end
          end
        end

        FIX: begin
          if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            Result      <= fix_res;
            zero        <= (fix_res == '0);
            negative    <= fix_res[XLEN-1];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed + random scoreboard bench for div_unit: results, flags, latency, kill and reset behaviour.
module tb_div_unit;

  localparam logic [31:0] T_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] T_ALL_ONES = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  DIVop;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic        zero;
  logic        negative;
  logic        div_by_zero;
  logic        overflow;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  div_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .kill        (kill),
    .A           (A),
    .B           (B),
    .DIVop       (DIVop),
    .busy        (busy),
    .done        (done),
    .Result      (Result),
    .zero        (zero),
    .negative    (negative),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written from the RV32M definition, independent of the iterative datapath.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : T_ALL_ONES;
    if (!op[0] && a == T_INT_MIN && b == T_ALL_ONES) return op[1] ? 32'd0 : T_INT_MIN;
    case (op)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    DIVop = op;
    A     = a;
    B     = b;
    e.tag = tag;
    e.res = model(op, a, b);
    e.dbz = (b == 32'd0);
    e.ovf = (b != 32'd0) && !op[0] && (a == T_INT_MIN) && (b == T_ALL_ONES);
    e.lat = (e.dbz || e.ovf) ? 1 : 34;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called right after the accept edge; lat counts sample points after that edge.
  task automatic wait_done();
    exp_t e;
    int   lat  = 0;
    bit   seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) chk("busy_after_accept", 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    chk({e.tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({e.tag, "_result"},   Result,               e.res);
      chk({e.tag, "_zero"},     32'(zero),            32'(e.res == 32'd0));
      chk({e.tag, "_negative"}, 32'(negative),        32'(e.res[31]));
      chk({e.tag, "_dbz"},      32'(div_by_zero),     32'(e.dbz));
      chk({e.tag, "_ovf"},      32'(overflow),        32'(e.ovf));
      chk({e.tag, "_latency"},  32'(lat),             32'(e.lat));
      chk({e.tag, "_busy_done"}, 32'(busy),           32'd1);
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int          n;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    A     = '0;
    B     = '0;
    DIVop = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(busy),        32'd0);
    chk("rst_done",   32'(done),        32'd0);
    chk("rst_result", Result,           32'd0);
    chk("rst_flags",  {28'd0, zero, negative, div_by_zero, overflow}, 32'd0);
    rst_n = 1'b1;

    issue("divu_100_7", 2'b01, 32'd100, 32'd7);
    wait_done();
    chk("divu_100_7_const", Result, 32'd14);
    @(negedge clk);
    chk("busy_clear_after_done", 32'(busy), 32'd0);

    issue("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    chk("rem_m7_2_const", Result, 32'hFFFF_FFFF);
    issue("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    chk("div_m7_2_const", Result, 32'hFFFF_FFFD);

    issue("div_5_0", 2'b00, 32'd5, 32'd0);
    wait_done();
    issue("remu_5_0", 2'b11, 32'd5, 32'd0);
    wait_done();
    chk("remu_5_0_const", Result, 32'd5);

    issue("div_ovf", 2'b00, T_INT_MIN, T_ALL_ONES);
    wait_done();
    issue("rem_ovf", 2'b10, T_INT_MIN, T_ALL_ONES);
    wait_done();
    chk("rem_ovf_zero_const", 32'(zero), 32'd1);

    // A second request held high throughout CALC and DONE must be ignored.
    issue("divu_9_3_held", 2'b01, 32'd9, 32'd3);
    start = 1'b1;
    A     = 32'd50;
    B     = 32'd5;
    wait_done();
    start = 1'b0;
    chk("held_const", Result, 32'd3);
    count_done(4, n);
    chk("held_no_reaccept_done", 32'(n), 32'd0);
    chk("held_no_reaccept_busy", 32'(busy), 32'd0);

    // kill together with start in IDLE accepts nothing.
    @(negedge clk);
    kill  = 1'b1;
    start = 1'b1;
    DIVop = 2'b01;
    A     = 32'd7;
    B     = 32'd1;
    @(posedge clk);
    #1 kill = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("kill_start_idle_busy", 32'(busy), 32'd0);

    // kill at edge N+10.
    issue("divu_kill", 2'b01, 32'd1000, 32'd3);
    sb.delete();
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    count_done(40, n);
    chk("kill_no_done", 32'(n), 32'd0);
    chk("kill_result_held", Result, 32'd3);

    issue("divu_8_2", 2'b01, 32'd8, 32'd2);
    wait_done();

    // Reset in the middle of CALC.
    issue("divu_rst", 2'b01, 32'd12345, 32'd11);
    sb.delete();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_done",   32'(done), 32'd0);
    chk("midrst_result", Result,    32'd0);
    chk("midrst_flags",  {28'd0, zero, negative, div_by_zero, overflow}, 32'd0);
    rst_n = 1'b1;
    count_done(40, n);
    chk("midrst_no_done", 32'(n), 32'd0);

    for (int k = 0; k < 8; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if (k == 7) rb = 32'd1;
      issue("rand", rop, ra, rb);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
